tc_timer: RTL and testbench

- Parametrised multi-digit timer. Successor to the single fixed mod-10 time counter.
- Counts radix-MOD digits, up or down, on ticks from an internal prescaler.
- Supports load, clear, wrap (auto-reload) and one-shot modes, and a registered carry/terminal pulse.
- Sits in the timing datapath and feeds display/control logic; carry_o cascades into further timers.

---
 rtl/tc_timer_pkg.sv | 22 ++
 rtl/tc_digit.sv | 53 +++++
 rtl/tc_timer.sv | 103 ++++++++++
 tb/tb_tc_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tc_timer_pkg.sv
// tc_timer_pkg: shared direction/mode encodings and load-value saturation helper.
`default_nettype none

package tc_timer_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    function automatic int unsigned sat_digit(input int unsigned value, input int unsigned mod);
        return (value >= mod) ? (mod - 1) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tc_digit.sv
// tc_digit: one radix-MOD counter digit with ripple carry/borrow in and out.
`default_nettype none

module tc_digit
    import tc_timer_pkg::*;
#(
    parameter int DW  = 4,
    parameter int MOD = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_step,
    input  dir_e          i_dir,
    input  logic          i_cin,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    output logic [DW-1:0] o_digit,
    output logic          o_cout
);

    localparam logic [DW-1:0] C_MAX = DW'(MOD - 1);

    logic [DW-1:0] r_digit;
    logic [DW-1:0] w_wrap_val;
    logic          w_at_wrap;

    // The value that rolls over depends on direction: MOD-1 going up, 0 going down.
    assign w_wrap_val = (i_dir == DIR_DOWN) ? '0 : C_MAX;
    assign w_at_wrap  = (r_digit == w_wrap_val);
    assign o_cout     = i_cin && w_at_wrap;
    assign o_digit    = r_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= DW'(sat_digit(32'(i_load_val), MOD));
        end else if (i_step && i_cin) begin
            if (w_at_wrap)
                r_digit <= (i_dir == DIR_DOWN) ? C_MAX : '0;
            else if (i_dir == DIR_DOWN)
                r_digit <= r_digit - 1'b1;
            else
                r_digit <= r_digit + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tc_timer.sv
// tc_timer: parametrised multi-digit up/down timer with prescaler, wrap/one-shot modes and carry pulse.
`default_nettype none

module tc_timer
    import tc_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DW       = 4,
    parameter int MOD      = 10,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [DIGITS*DW-1:0] load_val_i,
    input  logic                 dir_i,
    input  logic                 mode_i,
    output logic [DIGITS*DW-1:0] count_o,
    output logic                 tick_o,
    output logic                 carry_o,
    output logic                 done_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

    if (MOD < 2) begin : g_chk_mod_min
        $error("tc_timer: MOD must be at least 2");
    end
    if (MOD > (2 ** DW)) begin : g_chk_mod_max
        $error("tc_timer: MOD must fit in DW bits");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("tc_timer: PRESCALE must be at least 1");
    end
    if (DIGITS < 1) begin : g_chk_digits
        $error("tc_timer: DIGITS must be at least 1");
    end

    logic [PW-1:0]   r_pre;
    logic            r_carry;
    logic            r_done;
    logic            w_run;
    logic            w_terminal;
    logic            w_hold;
    logic            w_step;
    logic            w_sync_reset;
    logic [DIGITS:0] w_carry;

    assign w_run        = en_i && !r_done;
    assign tick_o       = w_run && (r_pre == C_PRE_LAST);
    assign w_sync_reset = clr_i || load_i;

    // The final ripple carry is high exactly when every digit sits at its wrap value.
    assign w_carry[0]  = 1'b1;
    assign w_terminal  = w_carry[DIGITS];
    assign w_hold      = w_terminal && (mode_e'(mode_i) == MODE_ONESHOT);
    assign w_step      = tick_o && !w_hold;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        tc_digit #(
            .DW  (DW),
            .MOD (MOD)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .i_step     (w_step),
            .i_dir      (dir_e'(dir_i)),
            .i_cin      (w_carry[gi]),
            .i_clr      (clr_i),
            .i_load     (load_i),
            .i_load_val (load_val_i[gi*DW +: DW]),
            .o_digit    (count_o[gi*DW +: DW]),
            .o_cout     (w_carry[gi+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_sync_reset) begin
            r_pre   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_run)
                r_pre <= (r_pre == C_PRE_LAST) ? '0 : r_pre + 1'b1;
            r_carry <= tick_o && w_terminal;
            if (tick_o && w_hold)
                r_done <= 1'b1;
        end
    end

    assign carry_o = r_carry;
    assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tc_timer.sv
// tb_tc_timer: scoreboard bench driving four tc_timer configurations from shared stimulus.
`default_nettype none

module tb_tc_timer;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, dir, mode;
    logic [7:0] lv;

    logic [7:0] cA, cB, cC;
    logic [3:0] cD;
    logic       tA, tB, tC, tD;
    logic       caA, caB, caC, caD;
    logic       dnA, dnB, dnC, dnD;

    always #5 clk = ~clk;

    tc_timer #(.DIGITS(2), .DW(4), .MOD(10), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .load_i(load), .load_val_i(lv),
        .dir_i(dir), .mode_i(mode), .count_o(cA), .tick_o(tA), .carry_o(caA), .done_o(dnA));
    tc_timer #(.DIGITS(2), .DW(4), .MOD(10), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .load_i(load), .load_val_i(lv),
        .dir_i(dir), .mode_i(mode), .count_o(cB), .tick_o(tB), .carry_o(caB), .done_o(dnB));
    tc_timer #(.DIGITS(2), .DW(4), .MOD(10), .PRESCALE(3)) u_c (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .load_i(load), .load_val_i(lv),
        .dir_i(dir), .mode_i(mode), .count_o(cC), .tick_o(tC), .carry_o(caC), .done_o(dnC));
    tc_timer #(.DIGITS(1), .DW(4), .MOD(2), .PRESCALE(1)) u_d (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .load_i(load), .load_val_i(lv[3:0]),
        .dir_i(dir), .mode_i(mode), .count_o(cD), .tick_o(tD), .carry_o(caD), .done_o(dnD));

    typedef struct {
        int         id;
        string      name;
        logic [7:0] cnt;
        logic       carry;
        logic       done;
        logic       tchk;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_state(input int id, input string nm, input logic [7:0] c,
                                input logic ca, input logic dn,
                                input logic tc = 1'b0, input logic tk = 1'b0);
        exp_t e;
        e.id = id; e.name = nm; e.cnt = c; e.carry = ca; e.done = dn; e.tchk = tc; e.tick = tk;
        q.push_back(e);
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Monitor: samples just after each rising edge and retires every expectation queued for it.
    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] ac;
        logic       aca, adn, atk;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
                0:       begin ac = cA;         aca = caA; adn = dnA; atk = tA; end
                1:       begin ac = cB;         aca = caB; adn = dnB; atk = tB; end
                2:       begin ac = cC;         aca = caC; adn = dnC; atk = tC; end
                default: begin ac = {4'h0, cD}; aca = caD; adn = dnD; atk = tD; end
            endcase
            total++;
            if (ac !== e.cnt || aca !== e.carry || adn !== e.done || (e.tchk && atk !== e.tick)) begin
                bad++;
                $display("FAIL %s: got cnt=%h carry=%b done=%b tick=%b, want cnt=%h carry=%b done=%b tick=%b",
                         e.name, ac, aca, adn, atk, e.cnt, e.carry, e.done,
                         e.tchk ? e.tick : atk);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0; mode = 1'b0; lv = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_state(0, "reset_a", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_state(1, "reset_b", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // Up, wrap: 01..99, then 00 with a carry pulse, then 01.
        en = 1'b1;
        for (int k = 1; k <= 101; k++) begin
            expect_state(0, "up_wrap", bcd(k % 100), (k == 100), 1'b0);
            @(negedge clk);
        end

        // Down, one-shot from 12.
        en = 1'b0; load = 1'b1; lv = 8'h12;
        expect_state(0, "load12", 8'h12, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0; en = 1'b1; dir = 1'b1; mode = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            expect_state(0, "down_os", bcd(12 - j), 1'b0, 1'b0);
            @(negedge clk);
        end
        expect_state(0, "os_term", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            expect_state(0, "os_hold", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
        end

        // Load clears done; clear wins over load.
        en = 1'b0; load = 1'b1; lv = 8'h37;
        expect_state(0, "load37", 8'h37, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1; lv = 8'h55; en = 1'b1;
        expect_state(0, "clr_over_load", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0;

        // Saturating load, then wrap from 99.
        load = 1'b1; lv = 8'hFA;
        expect_state(0, "load_sat", 8'h99, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        expect_state(0, "sat_wrap", 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        expect_state(0, "after_wrap", 8'h01, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset between edges.
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cA !== 8'h00 || caA !== 1'b0 || dnA !== 1'b0 || cB !== 8'h00) begin
            bad++;
            $display("FAIL async_rst: got a=%h carry=%b done=%b b=%h, want 00 0 0 00", cA, caA, dnA, cB);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        // Prescale 4: tick every 4th cycle, five ticks in 20 cycles.
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            expect_state(1, "pre4", 8'(k / 4), 1'b0, 1'b0, 1'b1, ((k % 4) == 3));
            @(negedge clk);
        end
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            expect_state(1, "en_low", 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            expect_state(1, "resume", (k == 4) ? 8'h06 : 8'h05, 1'b0, 1'b0, 1'b1, (k == 3));
            @(negedge clk);
        end

        // Prescale 3: direction flip mid-prescale at 50.
        en = 1'b0; load = 1'b1; lv = 8'h50;
        expect_state(2, "load50", 8'h50, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        expect_state(2, "flip_a", 8'h50, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        dir = 1'b1;
        expect_state(2, "flip_b", 8'h50, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        expect_state(2, "flip_c", 8'h49, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0; dir = 1'b0;

        // Single binary digit: alternating direction gives a terminal tick every cycle.
        load = 1'b1; lv = 8'h01;
        expect_state(3, "d1_load", 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        expect_state(3, "b2b_1", 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        dir = 1'b1;
        expect_state(3, "b2b_2", 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        dir = 1'b0;
        expect_state(3, "b2b_3", 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0;
        expect_state(3, "en_off", 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
